// File: rtl/sha256_pkg.sv
// Shared definitions for the nonce-scanning SHA-256 front end.
//   DIGEST_W / BLOCK_W : digest and message block widths
//   state_t            : scan sequencer states
//   lead_zero_ok()     : difficulty test on a digest (leading zero bits from MSB)
package sha256_pkg;

  localparam int unsigned DIGEST_W = 256;
  localparam int unsigned BLOCK_W  = 512;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK
  } state_t;

  // True when the top z bits of digest are all zero; z=0 always passes and
  // z=256 requires an all-zero digest (a shift by the full width yields 0).
  function automatic logic lead_zero_ok(input logic [DIGEST_W-1:0] digest,
                                        input int unsigned         z);
    logic [DIGEST_W-1:0] low_mask;
    low_mask = {DIGEST_W{1'b1}} >> z;
    return (digest & ~low_mask) == '0;
  endfunction

endpackage

// File: rtl/sha256_digest_serializer.sv
// Serial readout of a 256-bit digest in OUT_W-bit beats, MSB beat first.
//   inclk      : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   start_req  : request a stream; ignored while a stream is active
//   digest     : digest snapshot source, captured on the start cycle
//   hash       : current beat (0 when idle)
//   hash_valid : hash carries a valid beat; high for DIGEST_W/OUT_W cycles
module sha256_digest_serializer
  import sha256_pkg::*;
#(
  parameter int unsigned OUT_W = 8
) (
  input  logic                inclk,
  input  logic                reset_n,
  input  logic                start_req,
  input  logic [DIGEST_W-1:0] digest,
  output logic [OUT_W-1:0]    hash,
  output logic                hash_valid
);

  localparam int unsigned BEATS = DIGEST_W / OUT_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  // snap holds the beats not yet presented, left-aligned
  logic [DIGEST_W-1:0] snap;
  logic [CNT_W-1:0]    beat;

  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) begin
      snap       <= '0;
      beat       <= '0;
      hash       <= '0;
      hash_valid <= 1'b0;
    end else if (start_req && !hash_valid) begin
      hash       <= digest[DIGEST_W-1 -: OUT_W];
      snap       <= digest << OUT_W;
      beat       <= '0;
      hash_valid <= 1'b1;
    end else if (hash_valid) begin
      if (beat == LAST_BEAT) begin
        hash       <= '0;
        hash_valid <= 1'b0;
        beat       <= '0;
      end else begin
        hash <= snap[DIGEST_W-1 -: OUT_W];
        snap <= snap << OUT_W;
        beat <= beat + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sha256_nonce_scan.sv
// Nonce sweep around an external SHA-256 round core.
// Accepts a 512-bit block, substitutes successive nonces into the nonce field,
// launches the core per candidate and tests each digest for Z leading zeros.
//   inclk, reset_n          : clock / async active-low reset
//   blk_valid, block_n, ask : block feeder handshake (accept on ask & blk_valid)
//   core_start, core_block  : candidate launch to the round core
//   core_done, core_digest  : digest return from the round core
//   result                  : 0 = last check hit, 1 = miss / exhausted
//   found, exhausted        : one-cycle outcome pulses
//   nonce_out               : nonce of the last checked candidate
//   readout                 : request serial digest of the last checked candidate
//   hash, hash_valid        : serial digest stream, MSB beat first
module sha256_nonce_scan
  import sha256_pkg::*;
#(
  parameter int unsigned     Z         = 12,
  parameter int unsigned     OUT_W     = 8,
  parameter int unsigned     NONCE_W   = 32,
  parameter int unsigned     NONCE_LSB = 0,
  parameter longint unsigned MAX_TRIES = 64'd1 << NONCE_W
) (
  input  logic                inclk,
  input  logic                reset_n,
  input  logic                blk_valid,
  input  logic [BLOCK_W-1:0]  block_n,
  output logic                ask,
  output logic                core_start,
  output logic [BLOCK_W-1:0]  core_block,
  input  logic                core_done,
  input  logic [DIGEST_W-1:0] core_digest,
  output logic                result,
  output logic                found,
  output logic                exhausted,
  output logic [NONCE_W-1:0]  nonce_out,
  input  logic                readout,
  output logic [OUT_W-1:0]    hash,
  output logic                hash_valid
);

  localparam logic [NONCE_W-1:0] LAST_TRY = NONCE_W'(MAX_TRIES - 64'd1);

  state_t              state;
  logic [NONCE_W-1:0]  tries;     // also the current nonce value
  logic [DIGEST_W-1:0] digest_q;
  logic                checked;   // at least one CHECK since reset
  logic                readout_q;

  function automatic logic [BLOCK_W-1:0] set_nonce(input logic [BLOCK_W-1:0] blk,
                                                   input logic [NONCE_W-1:0] n);
    logic [BLOCK_W-1:0] r;
    r = blk;
    r[NONCE_LSB +: NONCE_W] = n;
    return r;
  endfunction

  // core_block doubles as the latched block: later candidates only rewrite
  // the nonce field in place, so no separate block register is kept.
  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ask        <= 1'b1;
      core_start <= 1'b0;
      core_block <= '0;
      result     <= 1'b1;
      found      <= 1'b0;
      exhausted  <= 1'b0;
      nonce_out  <= '0;
      digest_q   <= '0;
      tries      <= '0;
      checked    <= 1'b0;
    end else begin
      core_start <= 1'b0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
      case (state)
        IDLE: begin
          if (blk_valid) begin
            core_block <= set_nonce(block_n, '0);
            tries      <= '0;
            core_start <= 1'b1;
            ask        <= 1'b0;
            state      <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (core_done) begin
            digest_q  <= core_digest;
            nonce_out <= tries;
            state     <= CHECK;
          end
        end
        CHECK: begin
          checked <= 1'b1;
          if (lead_zero_ok(digest_q, Z)) begin
            result <= 1'b0;
            found  <= 1'b1;
            ask    <= 1'b1;
            state  <= IDLE;
          end else if (tries == LAST_TRY) begin
            result    <= 1'b1;
            exhausted <= 1'b1;
            ask       <= 1'b1;
            state     <= IDLE;
          end else begin
            tries      <= tries + 1'b1;
            core_block <= set_nonce(core_block, tries + 1'b1);
            core_start <= 1'b1;
            state      <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) readout_q <= 1'b0;
    else          readout_q <= readout;
  end

  sha256_digest_serializer #(
    .OUT_W (OUT_W)
  ) u_ser (
    .inclk      (inclk),
    .reset_n    (reset_n),
    .start_req  (readout_q && checked),
    .digest     (digest_q),
    .hash       (hash),
    .hash_valid (hash_valid)
  );

endmodule

// File: tb/tb_sha256_nonce_scan.sv
// Directed bench: four configurations of sha256_nonce_scan with stub round cores.
//   u0: Z=12, OUT_W=8, NONCE_W=32     hit at nonce 5
//   u1: Z=12, OUT_W=8, NONCE_W=3      never hits, last digest 01..20
//   u2: Z=0,  OUT_W=32                hit at nonce 0
//   u3: Z=256, NONCE_W=2, NONCE_LSB=100
module tb_sha256_nonce_scan;

  localparam logic [255:0] D0120 =
    256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n = 1'b0;
  logic [511:0] blk = '0;
  logic         blk_valid [4] = '{default: 1'b0};
  logic         readout   [4] = '{default: 1'b0};
  logic         done      [4] = '{default: 1'b0};
  logic [255:0] dig       [4] = '{default: '0};
  logic         ask [4], cs [4], result [4], found [4], exh [4], hv [4];
  logic [511:0] cb [4];
  logic [31:0]  nout0, nout2;
  logic [2:0]   nout1;
  logic [1:0]   nout3;
  logic [7:0]   hash0, hash1, hash3;
  logic [31:0]  hash2;

  int unsigned  starts [4] = '{default: 0};
  int unsigned  fnd    [4] = '{default: 0};
  int unsigned  exs    [4] = '{default: 0};
  int unsigned  lat    [4] = '{default: 0};
  logic [31:0]  nq     [4] = '{default: '0};
  logic [255:0] dig3_val = '0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  sha256_nonce_scan #(.Z(12), .OUT_W(8), .NONCE_W(32)) u0 (
    .inclk(clk), .reset_n(reset_n), .blk_valid(blk_valid[0]), .block_n(blk), .ask(ask[0]),
    .core_start(cs[0]), .core_block(cb[0]), .core_done(done[0]), .core_digest(dig[0]),
    .result(result[0]), .found(found[0]), .exhausted(exh[0]), .nonce_out(nout0),
    .readout(readout[0]), .hash(hash0), .hash_valid(hv[0]));

  sha256_nonce_scan #(.Z(12), .OUT_W(8), .NONCE_W(3)) u1 (
    .inclk(clk), .reset_n(reset_n), .blk_valid(blk_valid[1]), .block_n(blk), .ask(ask[1]),
    .core_start(cs[1]), .core_block(cb[1]), .core_done(done[1]), .core_digest(dig[1]),
    .result(result[1]), .found(found[1]), .exhausted(exh[1]), .nonce_out(nout1),
    .readout(readout[1]), .hash(hash1), .hash_valid(hv[1]));

  sha256_nonce_scan #(.Z(0), .OUT_W(32)) u2 (
    .inclk(clk), .reset_n(reset_n), .blk_valid(blk_valid[2]), .block_n(blk), .ask(ask[2]),
    .core_start(cs[2]), .core_block(cb[2]), .core_done(done[2]), .core_digest(dig[2]),
    .result(result[2]), .found(found[2]), .exhausted(exh[2]), .nonce_out(nout2),
    .readout(readout[2]), .hash(hash2), .hash_valid(hv[2]));

  sha256_nonce_scan #(.Z(256), .OUT_W(8), .NONCE_W(2), .NONCE_LSB(100)) u3 (
    .inclk(clk), .reset_n(reset_n), .blk_valid(blk_valid[3]), .block_n(blk), .ask(ask[3]),
    .core_start(cs[3]), .core_block(cb[3]), .core_done(done[3]), .core_digest(dig[3]),
    .result(result[3]), .found(found[3]), .exhausted(exh[3]), .nonce_out(nout3),
    .readout(readout[3]), .hash(hash3), .hash_valid(hv[3]));

  function automatic logic [255:0] model(input int k, input logic [31:0] n);
    case (k)
      0:       return (n == 32'd5) ? {32'h00080000, 224'h0} : '1;
      1:       return (n == 32'd7) ? D0120 : '1;
      2:       return D0120;
      default: return dig3_val;
    endcase
  endfunction

  // Stub round cores (3-cycle latency, not reset) and pulse counters.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      done[k] <= 1'b0;
      if (cs[k]) begin
        starts[k] <= starts[k] + 1;
        lat[k]    <= 3;
        nq[k]     <= (k == 1) ? {29'b0, cb[k][2:0]} : cb[k][31:0];
      end else if (lat[k] == 1) begin
        lat[k]  <= 0;
        done[k] <= 1'b1;
        dig[k]  <= model(k, nq[k]);
      end else if (lat[k] > 1) begin
        lat[k] <= lat[k] - 1;
      end
      if (found[k]) fnd[k] <= fnd[k] + 1;
      if (exh[k])   exs[k] <= exs[k] + 1;
    end
  end

  task automatic send(input int k, input logic [511:0] b);
    blk          = b;
    blk_valid[k] = 1'b1;
    @(negedge clk);
    blk_valid[k] = 1'b0;
  endtask

  task automatic wait_end(input int k, output bit ok);
    int unsigned f0, e0;
    f0 = fnd[k];
    e0 = exs[k];
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (fnd[k] != f0 || exs[k] != e0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({ask[k], cs[k], result[k], found[k], exh[k], hv[k]} !== 6'b101000) begin
        miscompares++;
        $display("FAIL reset_flags[%0d]: got %b expected 101000", k,
                 {ask[k], cs[k], result[k], found[k], exh[k], hv[k]});
      end
      vectors++;
      if (cb[k] !== '0) begin
        miscompares++;
        $display("FAIL reset_core_block[%0d]: got %0h expected 0", k, cb[k]);
      end
    end
    vectors++;
    if ({nout0, nout1, nout2, nout3, hash0, hash1, hash2, hash3} !== '0) begin
      miscompares++;
      $display("FAIL reset_nonce_hash: got %0h expected 0",
               {nout0, nout1, nout2, nout3, hash0, hash1, hash2, hash3});
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_readout_idle;
    int beats;
    beats = 0;
    readout[0] = 1'b1;
    @(negedge clk);
    readout[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (hv[0]) beats++;
      @(negedge clk);
    end
    vectors++;
    if (beats != 0) begin
      miscompares++;
      $display("FAIL readout_before_check: got %0d beats expected 0", beats);
    end
  endtask

  task automatic test_hit;
    logic [511:0] b, exp;
    int unsigned  s0, f0;
    bit           ok;
    b   = {16{32'hA5C3_0F1E}} ^ {480'h0, 32'hDEADBEEF};
    exp = b;
    exp[31:0] = '0;
    s0 = starts[0];
    f0 = fnd[0];
    send(0, b);
    vectors++;
    if (cs[0] !== 1'b1 || cb[0] !== exp) begin
      miscompares++;
      $display("FAIL hit_first_issue: got start=%b block=%0h expected start=1 block=%0h",
               cs[0], cb[0], exp);
    end
    wait_end(0, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL hit_timeout: got no outcome expected found pulse");
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (starts[0] - s0 != 6 || fnd[0] - f0 != 1) begin
      miscompares++;
      $display("FAIL hit_counts: got starts=%0d found=%0d expected starts=6 found=1",
               starts[0] - s0, fnd[0] - f0);
    end
    vectors++;
    if (result[0] !== 1'b0 || nout0 !== 32'd5 || ask[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL hit_outputs: got result=%b nonce=%0d ask=%b expected result=0 nonce=5 ask=1",
               result[0], nout0, ask[0]);
    end
  endtask

  task automatic test_exhaust;
    int unsigned s0, f0, e0;
    bit          ok;
    s0 = starts[1];
    f0 = fnd[1];
    e0 = exs[1];
    send(1, {16{32'h1234_5678}});
    wait_end(1, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL exhaust_timeout: got no outcome expected exhausted pulse");
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (starts[1] - s0 != 8 || exs[1] - e0 != 1 || fnd[1] != f0) begin
      miscompares++;
      $display("FAIL exhaust_counts: got starts=%0d exh=%0d found=%0d expected 8 1 0",
               starts[1] - s0, exs[1] - e0, fnd[1] - f0);
    end
    vectors++;
    if (result[1] !== 1'b1 || nout1 !== 3'd7 || ask[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL exhaust_outputs: got result=%b nonce=%0d ask=%b expected result=1 nonce=7 ask=1",
               result[1], nout1, ask[1]);
    end
  endtask

  // again_at >= 0 re-pulses readout when that many beats have been seen
  task automatic test_readout8(input int again_at);
    logic [255:0] d;
    logic [7:0]   e;
    int           beats;
    bit           gap, started;
    d = D0120;
    beats = 0;
    gap = 1'b0;
    started = 1'b0;
    readout[1] = 1'b1;
    @(negedge clk);
    readout[1] = 1'b0;
    for (int i = 0; i < 80; i++) begin
      readout[1] = (beats == again_at) && hv[1];
      if (hv[1]) begin
        e = (beats < 32) ? d[255 - 8 * beats -: 8] : 8'h00;
        vectors++;
        if (hash1 !== e) begin
          miscompares++;
          $display("FAIL beat8[%0d]: got %h expected %h", beats, hash1, e);
        end
        beats++;
        started = 1'b1;
      end else if (started && beats < 32) begin
        gap = 1'b1;
      end
      @(negedge clk);
    end
    readout[1] = 1'b0;
    vectors++;
    if (beats != 32 || gap) begin
      miscompares++;
      $display("FAIL beat8_count: got %0d beats gap=%b expected 32 beats gap=0", beats, gap);
    end
  endtask

  task automatic test_zero_difficulty;
    logic [255:0] d;
    int unsigned  s0;
    int           beats;
    bit           ok;
    d = D0120;
    s0 = starts[2];
    send(2, {16{32'hFFFF_0000}});
    wait_end(2, ok);
    vectors++;
    if (!ok || starts[2] - s0 != 1 || result[2] !== 1'b0 || nout2 !== 32'd0) begin
      miscompares++;
      $display("FAIL z0_hit: got ok=%b starts=%0d result=%b nonce=%0d expected 1 1 0 0",
               ok, starts[2] - s0, result[2], nout2);
    end
    beats = 0;
    readout[2] = 1'b1;
    @(negedge clk);
    readout[2] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (hv[2]) begin
        vectors++;
        if (beats >= 8 || hash2 !== d[255 - 32 * beats -: 32]) begin
          miscompares++;
          $display("FAIL beat32[%0d]: got %h expected %h", beats, hash2,
                   (beats < 8) ? d[255 - 32 * beats -: 32] : 32'h0);
        end
        beats++;
      end
      @(negedge clk);
    end
    vectors++;
    if (beats != 8) begin
      miscompares++;
      $display("FAIL beat32_count: got %0d expected 8", beats);
    end
  endtask

  task automatic test_z256;
    logic [511:0] b, exp;
    int unsigned  s0;
    bit           ok;
    b = {16{32'h5A5A_F00F}};
    exp = b;
    exp[101:100] = 2'b00;
    dig3_val = '0;
    s0 = starts[3];
    send(3, b);
    vectors++;
    if (cb[3] !== exp) begin
      miscompares++;
      $display("FAIL z256_field: got %0h expected %0h", cb[3], exp);
    end
    wait_end(3, ok);
    vectors++;
    if (!ok || starts[3] - s0 != 1 || result[3] !== 1'b0) begin
      miscompares++;
      $display("FAIL z256_zero_hit: got ok=%b starts=%0d result=%b expected 1 1 0",
               ok, starts[3] - s0, result[3]);
    end
    @(negedge clk);
    dig3_val = 256'h1;
    s0 = starts[3];
    send(3, b);
    wait_end(3, ok);
    vectors++;
    if (!ok || starts[3] - s0 != 4 || result[3] !== 1'b1 || nout3 !== 2'd3) begin
      miscompares++;
      $display("FAIL z256_one_miss: got ok=%b starts=%0d result=%b nonce=%0d expected 1 4 1 3",
               ok, starts[3] - s0, result[3], nout3);
    end
  endtask

  task automatic test_reset_mid_scan;
    int unsigned s_after, f0, e0;
    bit          ok;
    send(0, {16{32'h0BAD_CAFE}});
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    vectors++;
    if ({ask[0], cs[0], result[0], found[0], hv[0]} !== 5'b10100 || cb[0] !== '0 ||
        nout0 !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got flags=%b block=%0h nonce=%0h expected 10100 0 0",
               {ask[0], cs[0], result[0], found[0], hv[0]}, cb[0], nout0);
    end
    s_after = starts[0];
    f0 = fnd[0];
    e0 = exs[0];
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    vectors++;
    if (starts[0] != s_after || fnd[0] != f0 || exs[0] != e0 || ask[0] !== 1'b1 ||
        result[0] !== 1'b1 || nout0 !== '0) begin
      miscompares++;
      $display("FAIL late_done_ignored: got starts+%0d ask=%b result=%b nonce=%0d expected 0 1 1 0",
               starts[0] - s_after, ask[0], result[0], nout0);
    end
    send(0, {16{32'h7777_1111}});
    vectors++;
    if (cs[0] !== 1'b1 || cb[0][31:0] !== 32'h0) begin
      miscompares++;
      $display("FAIL rescan_nonce0: got start=%b nonce=%0h expected start=1 nonce=0",
               cs[0], cb[0][31:0]);
    end
    wait_end(0, ok);
    vectors++;
    if (!ok || starts[0] - s_after != 6 || nout0 !== 32'd5) begin
      miscompares++;
      $display("FAIL rescan_hit: got ok=%b starts=%0d nonce=%0d expected 1 6 5",
               ok, starts[0] - s_after, nout0);
    end
  endtask

  initial begin
    test_reset();
    test_readout_idle();
    test_hit();
    test_exhaust();
    test_readout8(-1);
    test_readout8(5);
    test_zero_difficulty();
    test_z256();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
